param_calculator: RTL and testbench
===================================

PARAM_CALCULATOR -- requirements
Module: param_calculator

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result bit width (legal range 4..16).
REQ-002 SHALL provide parameter CHAIN_EN, default 1, enables chaining the result into the next operand A.
REQ-003 SHALL provide port clk  input  1  single clock for all state.
REQ-004 SHALL provide port rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL provide port select_pulse  input  1  one-cycle, already debounced and edge-detected, commit/advance request.
REQ-006 SHALL provide port restart  input  1  debounced level; abort to IDLE while high.
REQ-007 SHALL provide port inc_pulse  input  1  one-cycle rotary clockwise step.
REQ-008 SHALL provide port dec_pulse  input  1  one-cycle rotary counter-clockwise step.
REQ-009 SHALL provide port disp_value  output  WIDTH  value for the hex display.
REQ-010 SHALL provide port disp_en  output  1  display enable.
REQ-011 SHALL provide port state_out  output  3  current state encoding.
REQ-012 SHALL provide port result  output  WIDTH  registered ALU result.
REQ-013 SHALL provide port led_flag  output  1  registered ALU flag.
REQ-014 SHALL provide port result_valid  output  1  high while result/led_flag hold a computed value.

Function
REQ-015 SHALL implement states IDLE=0, OPERAND_A=1, OPERAND_B=2, OP_SELECT=3, RESULT=4; codes 5..7 are unreachable and SHALL return to IDLE on the next edge.
REQ-016 SHALL apply transitions on select_pulse: IDLE->OPERAND_A, OPERAND_A->OPERAND_B, OPERAND_B->OP_SELECT, OP_SELECT->RESULT, RESULT->OPERAND_B if CHAIN_EN=1, else RESULT->IDLE.
REQ-017 SHALL give restart priority over select_pulse: restart high forces IDLE at the next edge from any state, with no register committed.
REQ-018 SHALL keep an entry register of WIDTH bits: +1 on inc_pulse alone, -1 on dec_pulse alone, unchanged when both or neither are asserted; it wraps modulo 2^WIDTH.
REQ-019 SHALL limit the entry register to 0..7 in OP_SELECT, wrapping 7->0 on inc and 0->7 on dec.
REQ-020 SHALL clear the entry register to 0 on every state change; steps arriving in the same cycle as a state change are discarded.
REQ-021 SHALL commit the pre-step entry value when select_pulse arrives: OPERAND_A->a_reg, OPERAND_B->b_reg, OP_SELECT->op_reg[2:0].
REQ-022 SHALL register result and led_flag on the OP_SELECT->RESULT edge, computed from a_reg, b_reg and the entry value (one edge of latency); result_valid rises on the same edge.
REQ-023 SHALL implement these opcodes, each with its flag:
  - 0 ADD a+b mod 2^WIDTH; flag = carry-out.
  - 1 SUB a-b mod 2^WIDTH; flag = borrow (a<b).
  - 2 AND, 3 OR, 4 XOR; flag = result==0.
  - 5 SHL a<<b[3:0], 6 SHR a>>b[3:0] (logical; shift >= WIDTH gives 0); flag = result==0.
  - 7 MUL, low WIDTH bits of a*b; flag = high WIDTH bits nonzero.
REQ-024 SHALL, when CHAIN_EN=1 and select_pulse arrives in RESULT, copy result into a_reg, clear result_valid and enter OPERAND_B.
REQ-025 SHALL drive disp_value as follows:
  - IDLE: 0, disp_en=0.
  - OPERAND_A/OPERAND_B: entry register, disp_en=1.
  - OP_SELECT: zero-extended entry[2:0], disp_en=1.
  - RESULT: result, disp_en=1.
REQ-026 SHALL hold result, led_flag and result_valid unchanged in every state except as set by REQ-022, REQ-024 and reset; entering IDLE via restart or select SHALL clear result_valid, result and led_flag.
REQ-027 SHALL produce all outputs from registers or from state-decoded register muxing, with no combinational path from any input to any output.

Reset
REQ-028 SHALL, on rst, set state=IDLE and clear a_reg, b_reg, op_reg, the entry register, result, led_flag and result_valid to 0; disp_value=0 and disp_en=0.
REQ-029 SHALL let rst abort any operation mid-flight, override all other inputs, and keep the block in IDLE until a select_pulse arrives after rst deasserts.

Verification
REQ-030 SHALL cover ADD with carry, WIDTH=8: enter A=0xF0 (240 incs), B=0x20, op=0 -> result=0x10, led_flag=1, result_valid=1 one edge after the final select.
REQ-031 SHALL cover wrap and clamp: in OPERAND_A, 1 dec -> disp_value=0xFF; in OP_SELECT, 1 dec from 0 -> disp_value=0x07; inc and dec in the same cycle -> value unchanged.
REQ-032 SHALL cover MUL and SUB: A=0x10, B=0x10, op=7 -> result=0x00, led_flag=1; A=0x03, B=0x05, op=1 -> result=0xFE, led_flag=1.
REQ-033 SHALL cover chaining with CHAIN_EN=1: after result=0x10, select -> state=OPERAND_B, result_valid=0; B=0x01, op=0 -> result=0x11, led_flag=0. With CHAIN_EN=0, the same select -> IDLE, result=0.
REQ-034 SHALL cover priority: restart and select_pulse in the same cycle in OPERAND_B -> IDLE, b_reg unchanged; select_pulse and inc_pulse in the same cycle -> the pre-increment value is committed.
REQ-035 SHALL cover reset: rst asserted in OP_SELECT with A/B loaded -> next edge IDLE with all outputs 0; a following select enters OPERAND_A with disp_value=0.

Source files
------------

// File: rtl/param_calculator.sv
// param_calculator: a four-step calculator.
// The user dials in operand A, operand B and an opcode with rotary steps and
// commits each value with select. The registered ALU result is shown on the display.
// State is visible on state_out.
// Input handshake: select_pulse, inc_pulse and dec_pulse are single-cycle strobes.
// Each one is acted on at the rising edge where it is high. No acknowledge is returned.
// restart is a level input. It holds the block in IDLE for as long as it is high.
module param_calculator #(
    parameter int WIDTH    = 8,
    parameter int CHAIN_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             select_pulse,
    input  logic             restart,
    input  logic             inc_pulse,
    input  logic             dec_pulse,
    output logic [WIDTH-1:0] disp_value,
    output logic             disp_en,
    output logic [2:0]       state_out,
    output logic [WIDTH-1:0] result,
    output logic             led_flag,
    output logic             result_valid
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_OPERAND_A = 3'd1,
        S_OPERAND_B = 3'd2,
        S_OP_SELECT = 3'd3,
        S_RESULT    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] entry_q, entry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_flag;
    logic [WIDTH:0]     sum_w;
    logic [2*WIDTH-1:0] prod_w;
    logic [3:0]         shamt;

    // ALU: operands come from a_q/b_q, and the opcode is the live entry value.
    always_comb begin
        sum_w    = {1'b0, a_q} + {1'b0, b_q};
        prod_w   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        shamt    = b_q[3:0];
        alu_res  = '0;
        alu_flag = 1'b0;
        case (entry_q[2:0])
            3'd0: begin
                alu_res  = sum_w[WIDTH-1:0];
                alu_flag = sum_w[WIDTH];
            end
            3'd1: begin
                alu_res  = a_q - b_q;
                alu_flag = (a_q < b_q);
            end
            3'd2: alu_res = a_q & b_q;
            3'd3: alu_res = a_q | b_q;
            3'd4: alu_res = a_q ^ b_q;
            3'd5: alu_res = (32'(shamt) >= WIDTH) ? '0 : (a_q << shamt);
            3'd6: alu_res = (32'(shamt) >= WIDTH) ? '0 : (a_q >> shamt);
            default: begin
                alu_res  = prod_w[WIDTH-1:0];
                alu_flag = |prod_w[2*WIDTH-1:WIDTH];
            end
        endcase
        // Logic and shift ops report a zero result on the flag.
        if (entry_q[2:0] inside {3'd2, 3'd3, 3'd4, 3'd5, 3'd6}) begin
            alu_flag = (alu_res == '0);
        end
    end

    // Next state: restart beats select, and select beats rotary steps.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        flag_d   = flag_q;
        valid_d  = valid_q;
        if (restart || (state_q > S_RESULT)) begin
            state_d = S_IDLE;
        end else if (select_pulse) begin
            case (state_q)
                S_IDLE:      state_d = S_OPERAND_A;
                S_OPERAND_A: begin
                    a_d     = entry_q;
                    state_d = S_OPERAND_B;
                end
                S_OPERAND_B: begin
                    b_d     = entry_q;
                    state_d = S_OP_SELECT;
                end
                S_OP_SELECT: begin
                    op_d     = entry_q[2:0];
                    result_d = alu_res;
                    flag_d   = alu_flag;
                    valid_d  = 1'b1;
                    state_d  = S_RESULT;
                end
                default: begin
                    if (CHAIN_EN != 0) begin
                        a_d     = result_q;
                        valid_d = 1'b0;
                        state_d = S_OPERAND_B;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end else if (inc_pulse != dec_pulse) begin
            // The opcode entry stays in the range 0..7. Operand entries wrap over the full width.
            if (state_q == S_OP_SELECT) begin
                entry_d = {{(WIDTH-3){1'b0}},
                           inc_pulse ? (entry_q[2:0] + 3'd1) : (entry_q[2:0] - 3'd1)};
            end else begin
                entry_d = inc_pulse ? (entry_q + WIDTH'(1)) : (entry_q - WIDTH'(1));
            end
        end
        // Each new state starts with a fresh entry, so any step in the changing cycle is dropped.
        if (state_d != state_q) begin
            entry_d = '0;
        end
        if (state_d == S_IDLE) begin
            result_d = '0;
            flag_d   = 1'b0;
            valid_d  = 1'b0;
        end
    end

    // State and datapath registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            entry_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            valid_q  <= valid_d;
        end
    end

    // Display mux, decoded from registered state only.
    always_comb begin
        disp_value = '0;
        disp_en    = 1'b0;
        case (state_q)
            S_OPERAND_A, S_OPERAND_B: begin
                disp_value = entry_q;
                disp_en    = 1'b1;
            end
            S_OP_SELECT: begin
                disp_value = {{(WIDTH-3){1'b0}}, entry_q[2:0]};
                disp_en    = 1'b1;
            end
            S_RESULT: begin
                disp_value = result_q;
                disp_en    = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_out    = state_q;
    assign result       = result_q;
    assign led_flag     = flag_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_param_calculator.sv
// Bench for param_calculator.
// Two instances share the same stimulus: one with chaining on and one with it off.
// A behavioural model is checked against both on every cycle.
// Directed cases also check hand-computed literals.
module tb_param_calculator;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic select_pulse = 1'b0;
  logic restart = 1'b0;
  logic inc_pulse = 1'b0;
  logic dec_pulse = 1'b0;

  logic [W-1:0] disp_c, res_c, disp_n, res_n;
  logic         en_c, flag_c, valid_c, en_n, flag_n, valid_n;
  logic [2:0]   st_c, st_n;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model state. Index 0 is the chaining instance and index 1 is the non-chaining one.
  int m_state[2] = '{0, 0};
  int m_entry[2] = '{0, 0};
  int m_a[2] = '{0, 0};
  int m_b[2] = '{0, 0};
  int m_res[2] = '{0, 0};
  int m_flag[2] = '{0, 0};
  int m_valid[2] = '{0, 0};

  logic [W:0] exp_q[$];

  param_calculator #(.WIDTH(W), .CHAIN_EN(1)) dut_c (
    .clk(clk), .rst(rst), .select_pulse(select_pulse), .restart(restart),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .disp_value(disp_c),
    .disp_en(en_c), .state_out(st_c), .result(res_c), .led_flag(flag_c),
    .result_valid(valid_c)
  );

  param_calculator #(.WIDTH(W), .CHAIN_EN(0)) dut_n (
    .clk(clk), .rst(rst), .select_pulse(select_pulse), .restart(restart),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .disp_value(disp_n),
    .disp_en(en_n), .state_out(st_n), .result(res_n), .led_flag(flag_n),
    .result_valid(valid_n)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic void alu(input int a, input int b, input int op, output int r, output int f);
    int sh;
    sh = b % 16;
    r = 0;
    f = 0;
    case (op)
      0: begin r = (a + b) % M; f = ((a + b) >= M) ? 1 : 0; end
      1: begin r = (a - b + M) % M; f = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sh >= W) ? 0 : (a * (1 << sh)) % M;
      6: r = (sh >= W) ? 0 : a / (1 << sh);
      default: begin r = (a * b) % M; f = ((a * b) >= M) ? 1 : 0; end
    endcase
    if (op >= 2 && op <= 6) f = (r == 0) ? 1 : 0;
  endfunction

  task automatic model_step(input int k, input bit chain);
    int nxt;
    int md;
    nxt = m_state[k];
    if (rst) begin
      m_state[k] = 0; m_entry[k] = 0; m_a[k] = 0; m_b[k] = 0;
      m_res[k] = 0; m_flag[k] = 0; m_valid[k] = 0;
    end else begin
      if (restart || m_state[k] > 4) begin
        nxt = 0;
      end else if (select_pulse) begin
        case (m_state[k])
          0: nxt = 1;
          1: begin m_a[k] = m_entry[k]; nxt = 2; end
          2: begin m_b[k] = m_entry[k]; nxt = 3; end
          3: begin
            alu(m_a[k], m_b[k], m_entry[k] % 8, m_res[k], m_flag[k]);
            m_valid[k] = 1;
            nxt = 4;
          end
          default: begin
            if (chain) begin m_a[k] = m_res[k]; m_valid[k] = 0; nxt = 2; end
            else nxt = 0;
          end
        endcase
      end else if (inc_pulse != dec_pulse) begin
        md = (m_state[k] == 3) ? 8 : M;
        m_entry[k] = (m_entry[k] + (inc_pulse ? 1 : md - 1)) % md;
      end
      if (nxt != m_state[k]) m_entry[k] = 0;
      if (nxt == 0) begin m_res[k] = 0; m_flag[k] = 0; m_valid[k] = 0; end
      m_state[k] = nxt;
    end
  endtask

  function automatic int exp_disp(input int k);
    case (m_state[k])
      1, 2: return m_entry[k];
      3: return m_entry[k] % 8;
      4: return m_res[k];
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    model_step(0, 1'b1);
    model_step(1, 1'b0);
  end

  // Compare both instances against the model on every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("c_state", st_c, m_state[0]);
      check("c_disp", disp_c, exp_disp(0));
      check("c_disp_en", en_c, (m_state[0] != 0) ? 1 : 0);
      check("c_result", res_c, m_res[0]);
      check("c_flag", flag_c, m_flag[0]);
      check("c_valid", valid_c, m_valid[0]);
      check("n_state", st_n, m_state[1]);
      check("n_disp", disp_n, exp_disp(1));
      check("n_disp_en", en_n, (m_state[1] != 0) ? 1 : 0);
      check("n_result", res_n, m_res[1]);
      check("n_flag", flag_n, m_flag[1]);
      check("n_valid", valid_n, m_valid[1]);
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input bit s, input bit i, input bit d, input bit rs, input bit r);
    select_pulse = s; inc_pulse = i; dec_pulse = d; restart = rs; rst = r;
    @(posedge clk);
    #1;
    select_pulse = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0; restart = 1'b0; rst = 1'b0;
  endtask

  task automatic sel();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter(input int v);
    if (v > M / 2) repeat (M - v) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    else repeat (v) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_op(input int a, input int b, input int op, input int r, input int f);
    logic [W:0] e;
    exp_q.push_back({f[0], r[W-1:0]});
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sel();
    enter(a); sel();
    enter(b); sel();
    enter(op); sel();
    e = exp_q.pop_front();
    check("op_result", res_c, e[W-1:0]);
    check("op_flag", flag_c, e[W]);
    check("op_valid", valid_c, 1);
    check("op_state", st_c, 4);
    check("op_result_nochain", res_n, e[W-1:0]);
  endtask

  typedef struct { int a; int b; int op; int r; int f; } vec_t;
  vec_t vecs[12] = '{
    '{'h10, 'h10, 7, 'h00, 1},
    '{'h03, 'h05, 1, 'hFE, 1},
    '{'h05, 'h03, 1, 'h02, 0},
    '{'hCC, 'hAA, 2, 'h88, 0},
    '{'h0F, 'hF0, 2, 'h00, 1},
    '{'h0C, 'h30, 3, 'h3C, 0},
    '{'h5A, 'h5A, 4, 'h00, 1},
    '{'h81, 'h01, 5, 'h02, 0},
    '{'h01, 'h13, 5, 'h08, 0},
    '{'h01, 'h18, 5, 'h00, 1},
    '{'h80, 'h09, 6, 'h00, 1},
    '{'h07, 'h09, 7, 'h3F, 0}
  };

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("rst_state", st_c, 0);
    check("rst_disp", disp_c, 0);
    check("rst_disp_en", en_c, 0);
    check("rst_result", res_c, 0);
    check("rst_valid", valid_c, 0);
    rst = 1'b0;

    // ADD with carry, then chaining
    run_op('hF0, 'h20, 0, 'h10, 1);
    check("add_disp", disp_c, 'h10);
    sel();
    check("chain_state", st_c, 2);
    check("chain_valid", valid_c, 0);
    check("chain_result_held", res_c, 'h10);
    check("nochain_state", st_n, 0);
    check("nochain_result", res_n, 0);
    enter(1); sel(); sel();
    check("chain2_result", res_c, 'h11);
    check("chain2_flag", flag_c, 0);
    check("chain2_valid", valid_c, 1);

    // wrap and clamp
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sel();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("wrap_a", disp_c, 'hFF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("both_steps_a", disp_c, 'hFF);
    sel(); sel();
    check("opsel_state", st_c, 3);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clamp_dec", disp_c, 'h07);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("both_steps_op", disp_c, 'h07);
    drive(1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("clamp_inc", disp_c, 'h00);

    // opcode table
    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].f);

    // select and inc in the same cycle commit the pre-step value
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sel(); enter(3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("selinc_state", st_c, 2);
    check("selinc_disp", disp_c, 0);
    enter(4); sel(); sel();
    check("selinc_result", res_c, 'h07);
    check("selinc_flag", flag_c, 0);
    // restart beats select
    sel(); enter(2);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_state", st_c, 0);
    check("restart_disp_en", en_c, 0);
    check("restart_result", res_c, 0);
    check("restart_valid", valid_c, 0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_hold", st_c, 0);

    // reset in OP_SELECT, after a chained result
    run_op('h22, 'h11, 0, 'h33, 0);
    sel(); enter(1); sel();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_state", st_c, 3);
    check("pre_rst_disp", disp_c, 2);
    check("pre_rst_result", res_c, 'h33);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("post_rst_state", st_c, 0);
    check("post_rst_disp", disp_c, 0);
    check("post_rst_disp_en", en_c, 0);
    check("post_rst_result", res_c, 0);
    check("post_rst_flag", flag_c, 0);
    check("post_rst_valid", valid_c, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_after_rst", st_c, 0);
    sel();
    check("rst_then_sel_state", st_c, 1);
    check("rst_then_sel_disp", disp_c, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
